// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream bundle carrying FIFO words to downstream DAC/sequencer logic.
interface fifo_stream_reader_if #(
    parameter int data_width = 16
);
    logic [data_width-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO drain reader: read strobes, 3-entry skid queue, valid/ready stream out.
// Optional m_tlast framing every burst_len beats when FIFO_READER_TLAST_EN is defined.
module fifo_stream_reader #(
    parameter int data_width = 16,
    parameter int len_width  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [len_width-1:0]  burst_len,
    input  logic [data_width-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic                  busy,
    fifo_stream_reader_if.master  m
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state;
    logic                  inflight;
    logic [1:0]            occ;
    logic [1:0]            occ_nxt;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [data_width-1:0] mem [3];
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] nxt_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign push       = inflight;
    assign pop        = m.m_tvalid & m.m_tready;
    assign m.m_tvalid = (occ != 2'd0);
    assign m.m_tdata  = mem[head];
    assign busy       = (state != IDLE);

    // Queued plus in-flight words must never exceed the queue depth.
    assign fifo_read = (state == RUN) & enable & ~fifo_empty &
                       (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= fifo_read;
            occ      <= occ_nxt;
            if (push) begin
                mem[tail] <= fifo_dout;
                tail      <= nxt_ptr(tail);
            end
            if (pop) begin
                head <= nxt_ptr(head);
            end
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                // Leave as the last word goes out so busy drops right after it.
                DRAIN:   if (occ_nxt == 2'd0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_READER_TLAST_EN
    logic [len_width-1:0] burst_q;
    logic [len_width-1:0] beat_cnt;
    logic                 last_beat;

    assign last_beat = (burst_q != '0) &&
                       (beat_cnt == burst_q - len_width'(1));
    assign m.m_tlast = m.m_tvalid & last_beat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_q  <= '0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            beat_cnt <= '0;
            if (enable) begin
                burst_q <= burst_len;
            end
        end else if (pop) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + len_width'(1);
        end
    end
`else
    logic unused_burst;

    assign unused_burst = ^burst_len;
    assign m.m_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a registered-read FIFO model.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] burst_len;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_read;
    logic        busy;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.data_width(16)) s ();

    fifo_stream_reader #(
        .data_width(16),
        .len_width (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .burst_len (burst_len),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .busy      (busy),
        .m         (s.master)
    );

    logic [15:0] fmem [64];
    int          wr = 0;
    int          rd = 0;
    logic        flush = 1'b0;

    assign fifo_empty = (rd == wr);

    always @(posedge clk) begin
        if (flush) begin
            rd <= wr;
        end else if (fifo_read && !fifo_empty) begin
            fifo_dout <= fmem[rd % 64];
            rd        <= rd + 1;
        end
    end

    int          cyc = 0;
    int          reads = 0;
    int          illegal = 0;
    int          stall_err = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    int          busy_fall = -1;
    logic [15:0] bdat [$];
    logic        blast [$];
    int          bcyc [$];
    logic        prev_stall = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_busy = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
            out_cnt    = 0;
        end else begin
            if (fifo_read) begin
                reads++;
                out_cnt++;
                if (fifo_empty) illegal++;
            end
            if (prev_stall && (s.m_tdata != prev_data ||
                               s.m_tlast != prev_last))
                stall_err++;
            if (s.m_tvalid && s.m_tready) begin
                bdat.push_back(s.m_tdata);
                blast.push_back(s.m_tlast);
                bcyc.push_back(cyc);
                out_cnt--;
            end
            if (out_cnt > max_out) max_out = out_cnt;
            if (prev_busy && !busy) busy_fall = cyc;
            prev_stall = s.m_tvalid && !s.m_tready;
            prev_data  = s.m_tdata;
            prev_last  = s.m_tlast;
            prev_busy  = busy;
        end
    end

    int   n_chk = 0;
    int   n_err = 0;
    int   b0 = 0;
    int   r0 = 0;
    int   e_cyc = 0;
    int   ph = 0;
    logic pat_en = 1'b0;
    logic exp_last [7];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bd(input int k);
        return (b0 + k < bdat.size()) ? bdat[b0 + k] : 16'hdead;
    endfunction

    function automatic logic bl(input int k);
        return (b0 + k < blast.size()) ? blast[b0 + k] : 1'bx;
    endfunction

    function automatic int bc(input int k);
        return (b0 + k < bcyc.size()) ? bcyc[b0 + k] : -100;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (pat_en) begin
            s.m_tready = (ph % 3 == 0);
            ph++;
        end
    endtask

    task automatic push_word(input logic [15:0] v);
        fmem[wr % 64] = v;
        wr++;
    endtask

    task automatic wait_beats(input int n, input int budget,
                              input string tag);
        int k = 0;
        while ((bdat.size() - b0) < n && k < budget) begin
            step();
            k++;
        end
        check(tag, bdat.size() - b0, n);
    endtask

    task automatic do_reset();
        enable     = 1'b0;
        s.m_tready = 1'b0;
        pat_en     = 1'b0;
        reset      = 1'b0;
        flush      = 1'b1;
        step();
        step();
        flush = 1'b0;
        reset = 1'b1;
        step();
        b0 = bdat.size();
        r0 = reads;
    endtask

    initial begin
        int k;
        reset      = 1'b0;
        enable     = 1'b0;
        burst_len  = 16'd0;
        s.m_tready = 1'b0;
        #1;
        check("rst_fifo_read", fifo_read, 0);
        check("rst_tvalid", s.m_tvalid, 0);
        check("rst_tdata", s.m_tdata, 0);
        check("rst_tlast", s.m_tlast, 0);
        check("rst_busy", busy, 0);

        // Basic stream
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        s.m_tready = 1'b1;
        enable     = 1'b1;
        e_cyc      = cyc;
        wait_beats(8, 40, "basic_count");
        check("basic_latency", bc(0) - e_cyc - 1, 3);
        check("basic_b2b", bc(7) - bc(0), 7);
        for (int i = 0; i < 8; i++) check("basic_data", bd(i), i + 1);
        check("basic_reads", reads - r0, 8);
        check("basic_busy", busy, 1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Backpressure with ready 1,0,0 repeating
        do_reset();
        for (int i = 0; i < 8; i++) push_word(16'hA0 + 16'(i));
        stall_err = 0;
        max_out   = 0;
        ph        = 0;
        pat_en    = 1'b1;
        enable    = 1'b1;
        wait_beats(8, 80, "bp_count");
        for (int i = 0; i < 10; i++) step();
        check("bp_no_extra", bdat.size() - b0, 8);
        for (int i = 0; i < 8; i++) check("bp_data", bd(i), 16'hA0 + i);
        check("bp_stall_stable", stall_err, 0);
        check("bp_outstanding_le3", max_out <= 3, 1);

        // Framing with burst_len 3
        do_reset();
        burst_len = 16'd3;
        for (int i = 0; i < 7; i++) push_word(16'h41 + 16'(i));
        s.m_tready = 1'b1;
        enable     = 1'b1;
        wait_beats(7, 40, "frame_count");
`ifdef FIFO_READER_TLAST_EN
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 7; i++) begin
            check("frame_data", bd(i), 16'h41 + i);
            check("frame_tlast", bl(i), exp_last[i]);
        end
        enable    = 1'b0;
        burst_len = 16'd0;
        for (int i = 0; i < 4; i++) step();

        // Drain: stall until 2 queued + 1 in flight, then drop enable
        do_reset();
        for (int i = 0; i < 6; i++) push_word(16'h31 + 16'(i));
        enable = 1'b1;
        k = 0;
        while (reads - r0 < 3 && k < 20) begin
            step();
            k++;
        end
        check("drain_fill_reads", reads - r0, 3);
        enable     = 1'b0;
        s.m_tready = 1'b1;
        wait_beats(3, 20, "drain_count");
        for (int i = 0; i < 5; i++) step();
        check("drain_no_extra", bdat.size() - b0, 3);
        for (int i = 0; i < 3; i++) check("drain_data", bd(i), 16'h31 + i);
        check("drain_reads", reads - r0, 3);
        check("drain_busy_fall", busy_fall - bc(2), 1);
        check("drain_busy_low", busy, 0);

        // Reset mid-stream with words queued
        do_reset();
        for (int i = 0; i < 6; i++) push_word(16'h21 + 16'(i));
        enable = 1'b1;
        k = 0;
        while (reads - r0 < 3 && k < 20) begin
            step();
            k++;
        end
        check("rstm_fill_reads", reads - r0, 3);
        #2;
        reset = 1'b0;
        #1;
        check("rstm_tvalid", s.m_tvalid, 0);
        check("rstm_tdata", s.m_tdata, 0);
        check("rstm_busy", busy, 0);
        check("rstm_fifo_read", fifo_read, 0);
        check("rstm_tlast", s.m_tlast, 0);
        enable = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("rstm_quiet", bdat.size() - b0, 0);
        check("rstm_no_reads", reads - r0, 3);
        s.m_tready = 1'b1;
        enable     = 1'b1;
        wait_beats(3, 30, "rstm_count");
        for (int i = 0; i < 3; i++) check("rstm_data", bd(i), 16'h24 + i);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Empty FIFO boundary
        do_reset();
        s.m_tready = 1'b1;
        enable     = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("empty_reads", reads - r0, 0);
        check("empty_beats", bdat.size() - b0, 0);
        push_word(16'h0055);
        wait_beats(1, 20, "empty_one_beat");
        for (int i = 0; i < 10; i++) step();
        check("empty_exact_one", bdat.size() - b0, 1);
        check("empty_data", bd(0), 16'h0055);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();

        check("no_read_when_empty", illegal, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain-side companion to the sample/instruction FIFO. Issues read strobes into the FIFO and accounts for its one-cycle registered read latency. Buffers returned words in a 3-entry skid queue and presents them as a valid/ready stream to downstream DAC/sequencer logic, with optional packet framing (`m_tlast`) every `burst_len` beats.

## Interface
- `data_width`, default 16: FIFO word and stream data width.
- `len_width`, default 16: width of `burst_len` and of the internal beat counter.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset; asserted (0) clears all state immediately.
- `enable` input, 1: run request; 1 = fetch and stream, 0 = stop fetching and drain.
- `burst_len` input, `len_width`: beats per packet; sampled on the IDLE→RUN transition; 0 = unframed (`m_tlast` never asserted).
- `fifo_dout` input, `data_width`: FIFO read data; valid the cycle after an accepted read.
- `fifo_empty` input, 1: FIFO empty flag.
- `fifo_read` output, 1: FIFO read strobe.
- `m_tdata` output, `data_width`: stream data.
- `m_tvalid` output, 1: stream data valid.
- `m_tready` input, 1: downstream accept.
- `m_tlast` output, 1: last beat of packet.
- `busy` output, 1: high in RUN or DRAIN.

## Operation
- **FIFO contract:** `fifo_read` asserted in cycle N with `fifo_empty`=0 → word on `fifo_dout` in N+1. `fifo_read` is never asserted while `fifo_empty`=1, so the FIFO's empty-read and simultaneous read/write-on-empty corners are never exercised.
- **Counters:** `inflight` (0/1) = read issued last cycle; `occ` (0..3) = words in skid queue.
- **Read issue (combinational):** `fifo_read` = (state==RUN) & `enable` & ~`fifo_empty` & (`occ`+`inflight` < 3). No path from `m_tready` to `fifo_read`.
- **Capture:** when `inflight`=1, `fifo_dout` is written to the queue tail.
- **Pop:** a beat is accepted when `m_tvalid` & `m_tready`; the queue head advances.
- **Ordering:** capture and pop in the same cycle keep `occ` unchanged. Order is strictly preserved. Queue pointers wrap modulo 3.
- **Output:** `m_tvalid` = (`occ` ≠ 0). `m_tdata` is the queue head.
- **Stall stability:** while `m_tvalid` & ~`m_tready`, `m_tdata` and `m_tlast` hold stable.
- **State machine (IDLE, RUN, DRAIN):**
  - IDLE→RUN: `enable`=1. Latch `burst_len`; clear beat counter.
  - RUN→DRAIN: `enable`=0. No new reads; in-flight and queued words still stream.
  - DRAIN→IDLE: `occ`=0 & `inflight`=0. Re-asserting `enable` in DRAIN has no effect until IDLE is reached; RUN is re-entered the cycle after.
- **Beat counter:** increments per accepted beat. Wraps to 0 on the beat that carries `m_tlast`. Cleared on IDLE entry.

## Timing
- **Reset values:** `fifo_read`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `busy`=0, state=IDLE, `occ`=0, `inflight`=0, beat counter=0.
- **Reset mid-operation:** queued and in-flight words are discarded; no further output until re-enabled.
- **Start latency:** `enable` rises in cycle E → RUN in E+1 → first `fifo_read` in E+1 (if FIFO non-empty).
- **Read-to-output latency:** `fifo_read` in N → `m_tvalid` in N+2.
- **Throughput:** 1 beat/cycle sustained with `m_tready`=1 and a non-empty FIFO.
- **Stall depth:** with `m_tready`=0, at most 3 words are fetched; then `fifo_read` stays low.
- **`m_tlast`:** asserted with beat index `burst_len`−1 (0-based) of every packet. With `burst_len`=1, asserted on every beat.
- **`busy`:** deasserts in the cycle IDLE is entered.

## Configuration
- **`FIFO_READER_TLAST_EN` defined:** `burst_len` latch, beat counter and `m_tlast` generation are compiled in as described above.
- **`FIFO_READER_TLAST_EN` undefined:** beat counter and latch are removed. `m_tlast` is tied to 0 and `burst_len` is ignored. Ports are unchanged.

## Test plan
- **Basic stream:** reset; FIFO preloaded with 0x0001..0x0008; `enable`=1, `m_tready`=1 → 8 beats on consecutive cycles, first `m_tvalid` 3 cycles after `enable`, data 0x0001..0x0008 in order, `fifo_read` never high while `fifo_empty`=1.
- **Backpressure:** 8 words, `m_tready` toggling 1,0,0,1,… → no loss or duplication; `m_tdata` stable across stalls; `occ` never exceeds 3.
- **Framing:** `FIFO_READER_TLAST_EN` defined, `burst_len`=3, 7 words → `m_tlast` on beats 3 and 6 only; beat 7 has `m_tlast`=0.
- **Drain:** `enable` dropped with 2 words queued and 1 in flight → exactly 3 more beats, `busy` falls the cycle after the last accepted beat, no further `fifo_read`.
- **Reset mid-stream:** assert `reset`=0 with `occ`=2 → all outputs 0 asynchronously; after release and `enable`, streaming resumes from the next unread FIFO word.
- **Empty boundary:** FIFO empty, `enable`=1 for 10 cycles → `fifo_read`=0 and `m_tvalid`=0 throughout; a single word written → exactly one beat emitted.
